inst_fetch_queue: RTL and testbench

Instruction fetch queue placed directly downstream of the program-counter stage in the MIPS32 pipeline. Each cycle in which the PC stage asserts its chip enable, the block captures the current PC together with the instruction word returned by the instruction ROM for that PC. It buffers the pair in a small FIFO and presents it to the decode stage through a valid/ready handshake. It also back-pressures the PC stage when full and discards all buffered work on a pipeline flush.

---
 rtl/inst_fetch_queue.sv | 97 +++++++++
 tb/tb_inst_fetch_queue.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue between the PC stage and decode.
// Captures {pc, inst} on ce_i, FWFT head with valid/ready, flush and stall.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   ce_i           PC stage fetch strobe; pc_i/inst_i captured when accepted
//   pc_i, inst_i   fetch address and ROM word for that address
//   flush_i        drop all queued entries and the current fetch
//   id_ready_i     decode consumes the head entry this cycle
//   if_valid_o     head entry valid
//   if_pc_o        head PC (0 when empty)
//   if_inst_o      head instruction (0 = NOP when empty)
//   fetch_stall_o  PC stage must hold; current fetch not captured
//   count_o        number of occupied entries
module inst_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ce_i,
    input  logic [AW-1:0]            pc_i,
    input  logic [DW-1:0]            inst_i,
    input  logic                     flush_i,
    input  logic                     id_ready_i,
    output logic                     if_valid_o,
    output logic [AW-1:0]            if_pc_o,
    output logic [DW-1:0]            if_inst_o,
    output logic                     fetch_stall_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [AW-1:0] pc_mem   [DEPTH];
    logic [DW-1:0] inst_mem [DEPTH];

    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic [PW:0]   count;

    logic empty;
    logic full;
    logic push;
    logic pop;

    assign empty = (count == '0);
    assign full  = (count == FULL);

    assign if_valid_o = ~empty;
    assign pop        = if_valid_o & id_ready_i;

    // A pop frees the slot in the same cycle, so a full queue that is
    // draining still accepts the fetch.
    assign fetch_stall_o = full & ~pop;
    assign push          = ce_i & ~flush_i & ~fetch_stall_o;

    // Empty head reads as zero so decode sees a NOP, not stale data.
    assign if_pc_o   = empty ? '0 : pc_mem[rp];
    assign if_inst_o = empty ? '0 : inst_mem[rp];
    assign count_o   = count;

    // Storage has no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            pc_mem[wp]   <= pc_i;
            inst_mem[wp] <= inst_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (flush_i) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wp <= wp + 1'b1;
            end
            if (pop) begin
                rp <= rp + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue.
// Directed scenarios plus random traffic against a queue-based model.
module tb_inst_fetch_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          ce_i;
    logic [AW-1:0] pc_i;
    logic [DW-1:0] inst_i;
    logic          flush_i;
    logic          id_ready_i;
    logic          if_valid_o;
    logic [AW-1:0] if_pc_o;
    logic [DW-1:0] if_inst_o;
    logic          fetch_stall_o;
    logic [2:0]    count_o;

    int compared   = 0;
    int mismatched = 0;

    logic [63:0] mq[$];
    logic [31:0] delivered[$];
    bit          model_ok = 0;

    always #5 clk = ~clk;

    inst_fetch_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .ce_i         (ce_i),
        .pc_i         (pc_i),
        .inst_i       (inst_i),
        .flush_i      (flush_i),
        .id_ready_i   (id_ready_i),
        .if_valid_o   (if_valid_o),
        .if_pc_o      (if_pc_o),
        .if_inst_o    (if_inst_o),
        .fetch_stall_o(fetch_stall_o),
        .count_o      (count_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check model before the edge,
    // update the model from the rules, then return at the next negedge.
    task automatic step(input logic r, input logic ce, input logic fl,
                        input logic rdy, input logic [31:0] pc);
        bit m_valid, m_pop, m_stall, m_push;
        logic [63:0] head;
        rst        = r;
        ce_i       = ce;
        flush_i    = fl;
        id_ready_i = rdy;
        pc_i       = pc;
        inst_i     = $urandom;
        #1;
        if (model_ok) begin
            m_valid = (mq.size() != 0);
            head    = m_valid ? mq[0] : 64'd0;
            m_pop   = m_valid && rdy;
            m_stall = (mq.size() == DEPTH) && !m_pop;
            m_push  = ce && !fl && !m_stall;
            chk("valid", {63'd0, if_valid_o}, {63'd0, m_valid});
            chk("head_pc", {32'd0, if_pc_o}, {32'd0, head[63:32]});
            chk("head_inst", {32'd0, if_inst_o}, {32'd0, head[31:0]});
            chk("stall", {63'd0, fetch_stall_o}, {63'd0, m_stall});
            chk("count", {61'd0, count_o}, 64'(mq.size()));
            if (r) begin
                mq.delete();
            end else begin
                if (m_pop) begin
                    delivered.push_back(head[63:32]);
                    void'(mq.pop_front());
                end
                if (fl) begin
                    mq.delete();
                end else if (m_push) begin
                    mq.push_back({pc, inst_i});
                end
            end
        end else if (r) begin
            mq.delete();
        end
        if (r) model_ok = 1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, {63'd0, if_valid_o}, 64'd0);
        chk({tag, "_pc"}, {32'd0, if_pc_o}, 64'd0);
        chk({tag, "_inst"}, {32'd0, if_inst_o}, 64'd0);
        chk({tag, "_count"}, {61'd0, count_o}, 64'd0);
    endtask

    initial begin
        logic [31:0] exp_pc[$];
        logic [31:0] nxt;
        int sent;
        int base;
        int cyc;
        bit tog;

        rst = 1; ce_i = 0; pc_i = 0; inst_i = 0; flush_i = 0; id_ready_i = 0;
        @(negedge clk);

        // Reset then fill
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk_idle("reset");
        chk("reset_stall", {63'd0, fetch_stall_o}, 64'd0);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 0, 32'(i * 4));
            chk("fill_head", {32'd0, if_pc_o}, 64'h0);
        end
        chk("fill_count", {61'd0, count_o}, 64'd4);
        ce_i = 0;
        #1;
        chk("full_stall", {63'd0, fetch_stall_o}, 64'd1);

        // Drain order
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
        chk_idle("drain");

        // Full with simultaneous push and pop
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 32'(i * 4));
        step(0, 1, 0, 1, 32'h10);
        chk("pp_count", {61'd0, count_o}, 64'd4);
        chk("pp_head", {32'd0, if_pc_o}, 64'h4);
        delivered.delete();
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
        chk("pp_ndel", 64'(delivered.size()), 64'd4);
        if (delivered.size() == 4) chk("pp_last", {32'd0, delivered[3]}, 64'h10);

        // Pointer wrap: 3*DEPTH sequential PCs, ready toggling
        delivered.delete();
        exp_pc.delete();
        sent = 0;
        base = 32'h200;
        tog = 1;
        cyc = 0;
        while ((sent < 3 * DEPTH || mq.size() != 0) && cyc < 200) begin
            nxt = 32'(base + sent * 4);
            if (sent < 3 * DEPTH) begin
                #1;
                if (!(mq.size() == DEPTH && !tog)) begin
                    exp_pc.push_back(nxt);
                    step(0, 1, 0, tog, nxt);
                    sent++;
                end else begin
                    step(0, 1, 0, tog, nxt);
                end
            end else begin
                step(0, 0, 0, tog, 0);
            end
            tog = !tog;
            cyc++;
        end
        chk("wrap_timeout", {63'd0, cyc >= 200}, 64'd0);
        chk("wrap_ndel", 64'(delivered.size()), 64'(3 * DEPTH));
        for (int i = 0; i < delivered.size() && i < exp_pc.size(); i++)
            chk("wrap_order", {32'd0, delivered[i]}, {32'd0, exp_pc[i]});

        // Flush
        step(0, 1, 0, 0, 32'h20);
        step(0, 1, 0, 0, 32'h24);
        step(0, 1, 0, 0, 32'h28);
        chk("pre_flush_count", {61'd0, count_o}, 64'd3);
        step(0, 1, 1, 0, 32'h2C);
        chk_idle("flush");
        step(0, 1, 0, 0, 32'h100);
        chk("post_flush_pc", {32'd0, if_pc_o}, 64'h100);
        chk("post_flush_valid", {63'd0, if_valid_o}, 64'd1);
        step(0, 0, 0, 1, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 2), $urandom_range(0, 1),
                 ($urandom_range(0, 99) < 4), $urandom_range(0, 1),
                 $urandom & 32'hFFFF_FFFC);
        end

        // Reset mid-operation
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 32'h300);
        step(0, 1, 0, 0, 32'h304);
        chk("pre_rst_count", {61'd0, count_o}, 64'd2);
        step(1, 1, 0, 0, 32'h308);
        rst = 0; ce_i = 0;
        #1;
        chk_idle("mid_rst");
        chk("mid_rst_stall", {63'd0, fetch_stall_o}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
